// File: rtl/max_scan_engine_if.sv
// max_scan_engine_if: data-memory bus between the scan engine and memory.
// Master drives address/data/strobes; slave returns combinational read data.
interface max_scan_engine_if;
  logic [31:0] mem_adr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_rd;
  logic        mem_wr;

  modport master (
    output mem_adr,
    output mem_din,
    output mem_rd,
    output mem_wr,
    input  mem_dout
  );

  modport slave (
    input  mem_adr,
    input  mem_din,
    input  mem_rd,
    input  mem_wr,
    output mem_dout
  );
endinterface

// File: rtl/max_scan_engine.sv
// max_scan_engine: scans LEN signed words, finds the max and its index,
// then writes both back to memory. All outputs decode registered state.
module max_scan_engine #(
  parameter logic [31:0] BASE_ADR = 32'd1000,
  parameter int          LEN      = 20,
  parameter logic [31:0] STRIDE   = 32'd4,
  parameter logic [31:0] MAX_ADR  = 32'd2000,
  parameter logic [31:0] IDX_ADR  = 32'd2004
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  max_scan_engine_if.master        mem,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [31:0]              o_max_val,
  output logic [31:0]              o_max_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WR_MAX = 3'd2;
  localparam logic [2:0] S_WR_IDX = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [31:0] LAST = 32'(LEN - 1);

  logic [2:0]  r_state;
  logic [31:0] r_i;
  logic [31:0] r_cur_max;
  logic [31:0] r_cur_idx;
  logic [31:0] r_max_val;
  logic [31:0] r_max_idx;

  logic        w_gt;
  logic [31:0] w_adr;
  logic [31:0] w_din;
  logic        w_rd;
  logic        w_wr;

  assign w_gt = $signed(mem.mem_dout) > $signed(r_cur_max);

  // FSM, element counter and running max/index tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_cur_max <= '0;
      r_cur_idx <= '0;
      r_max_val <= '0;
      r_max_idx <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_i     <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (r_i == '0 || w_gt) begin
            r_cur_max <= mem.mem_dout;
            r_cur_idx <= r_i;
          end
          r_i <= r_i + 32'd1;
          if (r_i == LAST)
            r_state <= S_WR_MAX;
        end
        S_WR_MAX: r_state <= S_WR_IDX;
        S_WR_IDX: begin
          r_max_val <= r_cur_max;
          r_max_idx <= r_cur_idx;
          r_state   <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory bus drive decoded from the current state only
  always_comb begin
    w_adr = '0;
    w_din = '0;
    w_rd  = 1'b0;
    w_wr  = 1'b0;
    unique case (r_state)
      S_READ: begin
        w_rd  = 1'b1;
        w_adr = BASE_ADR + r_i * STRIDE;
      end
      S_WR_MAX: begin
        w_wr  = 1'b1;
        w_adr = MAX_ADR;
        w_din = r_cur_max;
      end
      S_WR_IDX: begin
        w_wr  = 1'b1;
        w_adr = IDX_ADR;
        w_din = r_cur_idx;
      end
      default: ;
    endcase
  end

  assign mem.mem_adr = w_adr;
  assign mem.mem_din = w_din;
  assign mem.mem_rd  = w_rd;
  assign mem.mem_wr  = w_wr;

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_max_val = r_max_val;
  assign o_max_idx = r_max_idx;

endmodule

// File: tb/tb_max_scan_engine.sv
// tb_max_scan_engine: directed vectors for the max scan engine,
// one instance at LEN=20 and one at LEN=1, each with a memory model.
module tb_max_scan_engine;

  typedef struct {
    logic [19:0][31:0] el;
    logic [31:0]       emax;
    logic [31:0]       eidx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a;
  logic        start_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] mv_a, mi_a, mv_b, mi_b;

  int n_cmp = 0;
  int n_err = 0;

  max_scan_engine_if bus_a ();
  max_scan_engine_if bus_b ();

  max_scan_engine u_a (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start_a),
    .mem       (bus_a),
    .o_busy    (busy_a),
    .o_done    (done_a),
    .o_max_val (mv_a),
    .o_max_idx (mi_a)
  );

  max_scan_engine #(.LEN(1)) u_b (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start_b),
    .mem       (bus_b),
    .o_busy    (busy_b),
    .o_done    (done_b),
    .o_max_val (mv_b),
    .o_max_idx (mi_b)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_a [0:19];
  logic [31:0] mem_b0;
  logic [31:0] res_a_max = 32'hA5A5_A5A5;
  logic [31:0] res_a_idx = 32'hA5A5_A5A5;
  logic [31:0] res_b_max = 32'hA5A5_A5A5;
  logic [31:0] res_b_idx = 32'hA5A5_A5A5;
  logic        both_seen = 1'b0;
  logic [4:0]  ia;

  always_comb begin
    ia = 5'((bus_a.mem_adr - 32'd1000) >> 2);
    bus_a.mem_dout = 32'hDEAD_BEEF;
    if (bus_a.mem_rd && bus_a.mem_adr >= 32'd1000 &&
        bus_a.mem_adr < 32'd1080)
      bus_a.mem_dout = mem_a[ia];
  end

  always_comb begin
    bus_b.mem_dout = 32'hDEAD_BEEF;
    if (bus_b.mem_rd && bus_b.mem_adr == 32'd1000)
      bus_b.mem_dout = mem_b0;
  end

  always @(posedge clk) begin
    if (bus_a.mem_wr && bus_a.mem_adr == 32'd2000) res_a_max <= bus_a.mem_din;
    if (bus_a.mem_wr && bus_a.mem_adr == 32'd2004) res_a_idx <= bus_a.mem_din;
    if (bus_b.mem_wr && bus_b.mem_adr == 32'd2000) res_b_max <= bus_b.mem_din;
    if (bus_b.mem_wr && bus_b.mem_adr == 32'd2004) res_b_idx <= bus_b.mem_din;
  end

  always @(negedge clk) begin
    if ((bus_a.mem_rd && bus_a.mem_wr) || (bus_b.mem_rd && bus_b.mem_wr))
      both_seen = 1'b1;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input vec_t v);
    for (int k = 0; k < 20; k++) mem_a[k] = v.el[k];
  endtask

  task automatic scan_a(input int p1, input int p2,
                        output int lat, output int nd);
    lat = -1;
    nd  = 0;
    start_a = 1'b1;
    tick();
    for (int n = 1; n <= 50; n++) begin
      start_a = (n == p1) || (n == p2);
      if (n == 1) begin
        chk("busy_c1", 32'(busy_a), 32'd1);
        chk("rd_c1", 32'(bus_a.mem_rd), 32'd1);
        chk("adr_c1", bus_a.mem_adr, 32'd1000);
      end
      if (n == 2) chk("adr_c2", bus_a.mem_adr, 32'd1004);
      if (n == 21) begin
        chk("wrmax_adr", bus_a.mem_adr, 32'd2000);
        chk("wrmax_wr", 32'(bus_a.mem_wr), 32'd1);
      end
      if (n == 22) chk("wridx_adr", bus_a.mem_adr, 32'd2004);
      if (done_a) begin
        nd++;
        if (lat < 0) lat = n;
      end
      tick();
    end
    start_a = 1'b0;
  endtask

  initial begin
    vec_t tv [5];
    int   lat, nd, k;
    int   d [3];

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mem_b0 = 32'h8000_0000;

    for (int i = 0; i < 20; i++) begin
      tv[0].el[i] = 32'd0;
      tv[1].el[i] = 32'(-100 - i);
      tv[2].el[i] = 32'(i);
      tv[3].el[i] = 32'd5;
      tv[4].el[i] = 32'h8000_0000;
    end
    tv[0].el[0] = 32'd3;
    tv[0].el[1] = 32'd9;
    tv[0].el[2] = 32'hFFFF_FFFE;
    tv[0].el[3] = 32'd9;
    tv[0].el[4] = 32'd5;
    tv[0].emax = 32'd9;          tv[0].eidx = 32'd1;
    tv[1].el[19] = 32'hFFFF_FFF9;
    tv[1].emax = 32'hFFFF_FFF9;  tv[1].eidx = 32'd19;
    tv[2].emax = 32'd19;         tv[2].eidx = 32'd19;
    tv[3].emax = 32'd5;          tv[3].eidx = 32'd0;
    tv[4].el[7] = 32'h7FFF_FFFF;
    tv[4].emax = 32'h7FFF_FFFF;  tv[4].eidx = 32'd7;

    repeat (2) tick();
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_adr", bus_a.mem_adr, 32'd0);
    chk("rst_din", bus_a.mem_din, 32'd0);
    chk("rst_rd", 32'(bus_a.mem_rd), 32'd0);
    chk("rst_wr", 32'(bus_a.mem_wr), 32'd0);
    chk("rst_maxval", mv_a, 32'd0);
    chk("rst_maxidx", mi_a, 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 5; t++) begin
      load_a(tv[t]);
      scan_a(0, 0, lat, nd);
      chk("vec_latency", 32'(lat), 32'd23);
      chk("vec_ndone", 32'(nd), 32'd1);
      chk("vec_mem_max", res_a_max, tv[t].emax);
      chk("vec_mem_idx", res_a_idx, tv[t].eidx);
      chk("vec_max_val", mv_a, tv[t].emax);
      chk("vec_max_idx", mi_a, tv[t].eidx);
    end

    load_a(tv[0]);
    scan_a(5, 22, lat, nd);
    chk("ign_latency", 32'(lat), 32'd23);
    chk("ign_ndone", 32'(nd), 32'd1);
    chk("ign_mem_max", res_a_max, 32'd9);
    chk("ign_mem_idx", res_a_idx, 32'd1);

    load_a(tv[2]);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (9) tick();
    chk("mid_rd", 32'(bus_a.mem_rd), 32'd1);
    chk("mid_adr", bus_a.mem_adr, 32'd1036);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy_a), 32'd0);
    chk("mrst_done", 32'(done_a), 32'd0);
    chk("mrst_adr", bus_a.mem_adr, 32'd0);
    chk("mrst_din", bus_a.mem_din, 32'd0);
    chk("mrst_rd", 32'(bus_a.mem_rd), 32'd0);
    chk("mrst_wr", 32'(bus_a.mem_wr), 32'd0);
    chk("mrst_maxval", mv_a, 32'd0);
    chk("mrst_maxidx", mi_a, 32'd0);
    repeat (30) tick();
    chk("mrst_mem_max", res_a_max, 32'd9);
    chk("mrst_mem_idx", res_a_idx, 32'd1);
    scan_a(0, 0, lat, nd);
    chk("post_latency", 32'(lat), 32'd23);
    chk("post_mem_max", res_a_max, 32'd19);
    chk("post_mem_idx", res_a_idx, 32'd19);

    load_a(tv[1]);
    k = 0;
    d[0] = -1000; d[1] = -1000; d[2] = -1000;
    start_a = 1'b1;
    for (int n = 0; n < 120 && k < 3; n++) begin
      tick();
      if (done_a) begin
        d[k] = n;
        k++;
      end
    end
    start_a = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);
    chk("b2b_gap1", 32'(d[1] - d[0]), 32'd24);
    chk("b2b_gap2", 32'(d[2] - d[1]), 32'd24);
    for (int n = 0; n < 40 && busy_a; n++) tick();
    chk("b2b_idle", 32'(busy_a), 32'd0);
    chk("b2b_mem_max", res_a_max, 32'hFFFF_FFF9);
    chk("b2b_mem_idx", res_a_idx, 32'd19);

    lat = -1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      if (done_b) lat = n;
      else tick();
    end
    chk("len1_latency", 32'(lat), 32'd4);
    chk("len1_mem_max", res_b_max, 32'h8000_0000);
    chk("len1_mem_idx", res_b_idx, 32'd0);
    chk("len1_max_val", mv_b, 32'h8000_0000);
    chk("len1_max_idx", mi_b, 32'd0);

    chk("rd_wr_exclusive", 32'(both_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
